// File: rtl/ampl_pkg.sv
// Shared types and amplitude reduction helpers for the kernel amplitude bank.
package ampl_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Widest amplitude the helpers support; callers cast results down to their own width.
    localparam int AMPL_MAX_WID = 32;
    localparam int SUM_MAX_WID  = AMPL_MAX_WID + 2;

    typedef logic [AMPL_MAX_WID-1:0] ampl_t;
    typedef logic [SUM_MAX_WID-1:0]  ampl_sum_t;

    function automatic ampl_sum_t ampl_limit(input int unsigned wid);
        ampl_sum_t one;
        one = {{(SUM_MAX_WID-1){1'b0}}, 1'b1};
        return (one << wid) - one;
    endfunction

    function automatic logic ampl_over(input ampl_sum_t sum, input int unsigned wid);
        return (sum > ampl_limit(wid));
    endfunction

    // Clamp to the largest amplitude when saturating, otherwise keep the low bits.
    function automatic ampl_t ampl_reduce(input ampl_sum_t sum, input int unsigned wid,
                                          input logic sat_en);
        ampl_sum_t lim;
        ampl_sum_t res;
        lim = ampl_limit(wid);
        if (sat_en && (sum > lim)) begin
            res = lim;
        end else begin
            res = sum & lim;
        end
        return ampl_t'(res);
    endfunction

endpackage

// File: rtl/ampl_bank_ram.sv
// One amplitude channel: synchronous write, asynchronous read for the update
// pipeline and a registered read port that returns zero when not enabled.
module ampl_ram
    import ampl_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WID   = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WID-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr_a,
    output logic [WID-1:0]           rdata_a,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WID-1:0]           rdata
);

    logic [WID-1:0] mem_q [DEPTH];
    logic [WID-1:0] rdata_d;
    logic [WID-1:0] rdata_q;

    // Storage array; contents are cleared by the owner's sweep, not by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];

    // Registered port reads the pre-write contents, giving read-before-write.
    always_comb begin
        if (re) begin
            rdata_d = mem_q[raddr];
        end else begin
            rdata_d = {WID{1'b0}};
        end
    end

    // Read output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= {WID{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ampl_bank.sv
// Per-neuron kernel amplitude bank with load/accumulate updates and a post-reset
// clear sweep. Define AMPL_SAT_EN to clamp overflowing sums and report sat_evt.
module ampl_bank
    import ampl_pkg::*;
#(
    parameter int NEURON_NO = 256,
    parameter int KER_NO    = 2,
    parameter int AMPL_WID  = 12,
    parameter int W_WID     = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sp_in,
    input  logic                         sp_out,
    input  logic                         accum,
    input  logic [$clog2(NEURON_NO)-1:0] wr_addr,
    input  logic [W_WID-1:0]             weight,
    input  logic [KER_NO*AMPL_WID-1:0]   ker_in,
    input  logic                         re,
    input  logic [$clog2(NEURON_NO)-1:0] rd_addr,
    output logic [KER_NO*AMPL_WID-1:0]   ampl_out,
    output logic                         rd_valid,
    output logic                         init_busy,
    output logic                         sat_evt
);

    localparam int ADDR_WID = $clog2(NEURON_NO);
    localparam int SUM_WID  = AMPL_WID + 2;

`ifdef AMPL_SAT_EN
    localparam logic SAT_EN = 1'b1;
    logic [KER_NO-1:0] clamp_s;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_t                     state_q, state_d;
    logic [ADDR_WID-1:0]        cnt_q, cnt_d;
    logic                       init_s, run_s;

    logic                       w1_valid_q, w1_valid_d;
    logic                       w1_clr_q, w1_clr_d;
    logic                       w1_acc_q, w1_acc_d;
    logic [ADDR_WID-1:0]        w1_addr_q, w1_addr_d;
    logic [W_WID-1:0]           w1_weight_q, w1_weight_d;
    logic [KER_NO*AMPL_WID-1:0] w1_ker_q, w1_ker_d;

    logic                       ram_we_s;
    logic [ADDR_WID-1:0]        ram_waddr_s;
    logic                       rd_en_s;
    logic                       rd_valid_q, rd_valid_d;
    logic                       sat_evt_q, sat_evt_d;

    // FSM state and sweep counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= {ADDR_WID{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep one address per cycle, then run forever.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + ADDR_WID'(1);
                if (cnt_q == ADDR_WID'(NEURON_NO - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = {ADDR_WID{1'b0}};
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        init_s = 1'b0;
        run_s  = 1'b0;
        case (state_q)
            ST_INIT: init_s = 1'b1;
            ST_RUN:  run_s  = 1'b1;
            default: init_s = 1'b1;
        endcase
    end

    assign init_busy = init_s;

    // W1 capture; requests seen during the sweep are dropped.
    always_comb begin
        w1_valid_d  = run_s & (sp_in | sp_out);
        w1_clr_d    = sp_out;
        w1_acc_d    = accum;
        w1_addr_d   = wr_addr;
        w1_weight_d = weight;
        w1_ker_d    = ker_in;
    end

    // W1 pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            w1_valid_q  <= 1'b0;
            w1_clr_q    <= 1'b0;
            w1_acc_q    <= 1'b0;
            w1_addr_q   <= {ADDR_WID{1'b0}};
            w1_weight_q <= {W_WID{1'b0}};
            w1_ker_q    <= {(KER_NO*AMPL_WID){1'b0}};
        end else begin
            w1_valid_q  <= w1_valid_d;
            w1_clr_q    <= w1_clr_d;
            w1_acc_q    <= w1_acc_d;
            w1_addr_q   <= w1_addr_d;
            w1_weight_q <= w1_weight_d;
            w1_ker_q    <= w1_ker_d;
        end
    end

    // Shared RAM write port: the sweep owns it until the bank is running.
    always_comb begin
        if (init_s) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = cnt_q;
        end else begin
            ram_we_s    = w1_valid_q;
            ram_waddr_s = w1_addr_q;
        end
    end

    assign rd_en_s = re & run_s;

    for (genvar k = 0; k < KER_NO; k++) begin : g_ch
        logic [AMPL_WID-1:0] stored_s;
        logic [AMPL_WID-1:0] ker_s;
        logic [AMPL_WID-1:0] new_s;
        logic [AMPL_WID-1:0] wdata_s;
        logic [AMPL_WID-1:0] rdata_s;
        logic [SUM_WID-1:0]  sum_s;

        // W2 read-modify-write arithmetic for this channel.
        always_comb begin
            ker_s = w1_ker_q[k*AMPL_WID +: AMPL_WID];
            sum_s = SUM_WID'(w1_weight_q) + SUM_WID'(ker_s);
            if (w1_acc_q) begin
                sum_s = sum_s + SUM_WID'(stored_s);
            end else begin
                sum_s = sum_s;
            end
            if (w1_clr_q) begin
                new_s = {AMPL_WID{1'b0}};
            end else begin
                new_s = AMPL_WID'(ampl_reduce(SUM_MAX_WID'(sum_s), AMPL_WID, SAT_EN));
            end
            if (init_s) begin
                wdata_s = {AMPL_WID{1'b0}};
            end else begin
                wdata_s = new_s;
            end
        end

`ifdef AMPL_SAT_EN
        assign clamp_s[k] = ampl_over(SUM_MAX_WID'(sum_s), AMPL_WID);
`endif

        ampl_ram #(
            .DEPTH (NEURON_NO),
            .WID   (AMPL_WID)
        ) u_ram (
            .clk     (clk),
            .reset   (reset),
            .we      (ram_we_s),
            .waddr   (ram_waddr_s),
            .wdata   (wdata_s),
            .raddr_a (w1_addr_q),
            .rdata_a (stored_s),
            .re      (rd_en_s),
            .raddr   (rd_addr),
            .rdata   (rdata_s)
        );

        assign ampl_out[k*AMPL_WID +: AMPL_WID] = rdata_s;
    end

    // Status next-values; a clear never reports saturation.
    always_comb begin
        rd_valid_d = rd_en_s;
`ifdef AMPL_SAT_EN
        sat_evt_d  = w1_valid_q & ~w1_clr_q & run_s & (|clamp_s);
`else
        sat_evt_d  = 1'b0;
`endif
    end

    // Status output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            sat_evt_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            sat_evt_q  <= sat_evt_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign sat_evt  = sat_evt_q;

endmodule

// File: doc/ampl_bank.md
# ampl_bank

Per-neuron synaptic kernel amplitude store, generalised to KER_NO kernel channels (A, B, … per neuron) with a load-or-accumulate write mode. A registered write pipeline performs the update as a read-modify-write, and a post-reset clear sweep zeroes the RAM. It sits between the spike router (sp_in/sp_out events) and the kernel evaluator, which reads amplitudes through the registered read port.

## Interface
- NEURON_NO, 256, neuron count; power of two.
- KER_NO, 2, kernel channels per neuron; 1 to 8.
- AMPL_WID, 12, amplitude width per channel.
- W_WID, 12, weight width; W_WID ≤ AMPL_WID.
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- sp_in  in  1  input-spike update request at wr_addr.
- sp_out  in  1  output spike; clears all channels at wr_addr; priority over sp_in.
- accum  in  1  sp_in mode: 0 = load, 1 = accumulate.
- wr_addr  in  $clog2(NEURON_NO)  write/update neuron index.
- weight  in  W_WID  synaptic weight, unsigned.
- ker_in  in  KER_NO*AMPL_WID  per-channel kernel offsets; channel k in bits [k*AMPL_WID +: AMPL_WID].
- re  in  1  read enable.
- rd_addr  in  $clog2(NEURON_NO)  read neuron index.
- ampl_out  out  KER_NO*AMPL_WID  registered amplitudes; same channel packing as ker_in.
- rd_valid  out  1  ampl_out holds RAM data.
- init_busy  out  1  clear sweep in progress; requests are ignored.
- sat_evt  out  1  one-cycle pulse when an update saturated (see Configuration).

## Operation
- FSM states ST_INIT and ST_RUN. Reset forces ST_INIT with sweep counter 0.
- ST_INIT: writes zero to all channels at the counter address, one address per cycle. Leaves for ST_RUN after address NEURON_NO-1.
- In ST_INIT, sp_in, sp_out and re are ignored (dropped, not queued).
- ST_RUN write pipeline:
  - Stage W1 registers {sp_out, sp_in, accum, wr_addr, weight, ker_in}.
  - Stage W2 reads the stored value combinationally at the W1 address and writes the result at the next edge.
- Update rule per channel k:
  - sp_out: new = 0.
  - sp_in & !accum: new = weight + ker[k].
  - sp_in & accum: new = stored[k] + weight + ker[k].
  - Sums are computed at AMPL_WID+2 bits, zero-extended, then reduced per Configuration.
- sp_in and sp_out asserted together: clear only. No sat_evt.
- Back-to-back updates to one address need no forwarding: W2 of cycle n+1 reads the value committed at the end of cycle n.
- Read port: with re in ST_RUN, ampl_out = RAM[rd_addr] and rd_valid = 1 at the next edge. Otherwise ampl_out = 0 and rd_valid = 0.

## Timing
- Reset values: ampl_out = 0, rd_valid = 0, init_busy = 1, sat_evt = 0.
- Sweep: init_busy stays high for NEURON_NO cycles after reset deasserts. The first accepted request is on cycle NEURON_NO after release.
- Reset mid-sweep restarts the counter at 0. Reset in ST_RUN drops any W1 request in flight, and RAM contents are re-cleared by the sweep.
- Write latency: request sampled at edge N commits at edge N+1.
- Read-during-write is read-before-write:
  - A read sampled at edge N+1 for the same address returns the old value.
  - A read sampled at edge N+2 or later returns the new value.
- Read latency: 1 cycle. Reads and writes are independent every cycle.
- sat_evt is asserted in the cycle after the W2 commit edge, for one cycle.

## Configuration
- AMPL_SAT_EN defined:
  - Any channel sum > 2^AMPL_WID-1 clamps to 2^AMPL_WID-1.
  - sat_evt pulses if any channel clamped.
- AMPL_SAT_EN undefined:
  - Sums are truncated to the low AMPL_WID bits (modulo wrap).
  - sat_evt is tied 0.

## Structure
- Package ampl_pkg:
  - state_t enum {ST_INIT, ST_RUN}.
  - Parameterised ampl_t width helper.
  - Function ampl_reduce(sum, sat_en) implementing clamp or wrap.
- Sub-module ampl_ram:
  - One channel of distributed RAM, NEURON_NO x AMPL_WID.
  - One synchronous write port, one asynchronous read port for W2, one registered read port.
  - Instantiated KER_NO times via generate.
- Top level holds the FSM, sweep counter, W1 register and per-channel update arithmetic.

## Test plan
- Reset, then hold re=1, rd_addr=5 → init_busy high for exactly 256 cycles, rd_valid=0 throughout. After the sweep, ampl_out = 0 with rd_valid = 1.
- Load: sp_in, accum=0, addr 3, weight 100, ker {7, 20} → reading addr 3 two cycles later gives channel0 = 107, channel1 = 120.
- Accumulate twice back-to-back on addr 3 with weight 10 and ker {0, 0} → channel0 reads 127, channel1 reads 140; no lost update.
- sp_in and sp_out together on addr 3 → both channels read 0; sat_evt = 0.
- Accumulate on addr 9 holding 4090, weight 10, ker 0:
  - with AMPL_SAT_EN → reads 4095 and sat_evt pulses once.
  - without AMPL_SAT_EN → reads 4.
- Reset asserted at sweep address 100 → counter restarts at 0 and init_busy lasts another full 256 cycles. Read of addr 3 after the sweep returns 0.
